alu_access_ctrl: RTL and testbench
==================================

# alu_access_ctrl

Sequencing and arbitration controller that shares the single combinational floating-point ALU (add/sub/mul/div/OR/AND/NOT, 3-bit opcode) between two requesters. It accepts one operation at a time over a valid/ready handshake, chosen by round-robin. It holds the ALU inputs stable for a programmable settle window, captures the result and flags, and returns them over a response handshake tagged with the requester id. It sits directly in front of the ALU instance, and it is the only driver of the ALU's operand and opcode inputs.

## Interface
- SETTLE_CYCLES, 2, cycles the ALU inputs are held before capture (legal range 1..15)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req0_valid / req1_valid  in  1  requester n has an operation pending
- req0_ready / req1_ready  out  1  operation accepted this cycle when valid and ready are both high
- req0_operand_a / req1_operand_a  in  32  IEEE-754 single operand A
- req0_operand_b / req1_operand_b  in  32  IEEE-754 single operand B
- req0_operation / req1_operation  in  3  ALU opcode, 1..7
- alu_operand_a, alu_operand_b  out  32  driven to the ALU
- alu_operation  out  3  driven to the ALU; 0 = parked
- alu_result  in  32  ALU result
- alu_exception, alu_overflow, alu_underflow  in  1  ALU flags
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts the response
- resp_id  out  1  requester that issued the operation
- resp_result  out  32  captured result
- resp_exception, resp_overflow, resp_underflow  out  1  captured flags
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - If only one requester is valid, it is granted.
  - If both are valid, the port not equal to last_grant is granted.
  - req_ready is high only for the granted port, and only in IDLE. It is a combinational function of the valids and the state.
  - On a handshake: latch operands, opcode and id; set last_grant = id.
  - A valid opcode (1..7) moves to ISSUE. Opcode 0 goes straight to RESP with result 0, exception=1, overflow=0, underflow=0, and the ALU is never driven.
- **ISSUE**
  - alu_operand_a, alu_operand_b and alu_operation come from the latched registers and stay constant for SETTLE_CYCLES cycles.
  - A down-counter is loaded with SETTLE_CYCLES-1 on entry. When it reads 0, the edge captures alu_result and all three flags and moves to RESP.
- **RESP**
  - resp_* outputs come from registers and stay stable while resp_valid=1 and resp_ready=0.
  - The edge where resp_valid and resp_ready are both high returns to IDLE.
  - No new request is accepted in that same cycle.
- In IDLE and RESP the ALU outputs are parked: operands 0, alu_operation 0.
- Requester inputs are ignored outside IDLE. A valid request simply waits.
- Flags pass through unmodified; the block does not interpret them.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (port 0 wins the first contention).
  - All req_ready, resp_valid and busy = 0.
  - resp_result and all resp flags = 0, resp_id = 0.
  - alu_operand_a/b = 0, alu_operation = 0.
- Accept at edge T:
  - ALU driven in cycles T+1 .. T+SETTLE_CYCLES.
  - Capture at the end of cycle T+SETTLE_CYCLES.
  - resp_valid = 1 from cycle T+SETTLE_CYCLES+1.
- Opcode 0: resp_valid = 1 in cycle T+1.
- Best-case throughput: one op per SETTLE_CYCLES+2 cycles, with resp_ready tied high.
- Reset asserted mid-ISSUE or mid-RESP: all state clears immediately. The in-flight operation is discarded and no response is ever produced. The first request after reset release is accepted normally.
- A request that deasserts valid before its handshake leaves no trace.
- last_grant is updated only on a handshake, never on a grant alone.

## Test plan
- Single add, SETTLE_CYCLES=2:
  - Stimulus: port0 valid, a=32'h3F800000, b=32'h40000000, op=1, accepted at edge T.
  - Response: alu_operation=1 in T+1..T+2; resp_valid at T+3 with resp_result=32'h40400000, resp_id=0, all flags 0.
- Contention:
  - Stimulus: both ports valid continuously from reset, port0 op=3, port1 op=2.
  - Response: grants alternate 0,1,0,1 over four operations; resp_id alternates to match.
- Backpressure:
  - Stimulus: resp_ready held 0 for 5 cycles after resp_valid rises.
  - Response: resp_* stable; both req_ready stay 0; busy=1. One cycle after resp_ready=1, IDLE accepts the next request.
- Opcode 0:
  - Stimulus: port1 sends op=0.
  - Response: resp_valid one cycle after accept, result 0, exception=1, resp_id=1; alu_operation never leaves 0.
- Flag passthrough:
  - Stimulus: port0 op=5 with a=32'h7F800000.
  - Response: resp_exception=1, resp_result=0.
- Reset mid-ISSUE:
  - Stimulus: rst_n low in the first ISSUE cycle.
  - Response: all outputs return to reset values in the same cycle; resp_valid never rises for that op. After reset release a fresh request completes correctly.

Source files
------------

// File: rtl/alu_access_ctrl.sv
// Round-robin access controller for a shared combinational FP ALU.
// Holds ALU inputs for SETTLE_CYCLES, captures result/flags, returns a tagged response.
module alu_access_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_operand_a,
    input  logic [31:0] req1_operand_a,
    input  logic [31:0] req0_operand_b,
    input  logic [31:0] req1_operand_b,
    input  logic [2:0]  req0_operation,
    input  logic [2:0]  req1_operation,
    output logic [31:0] alu_operand_a,
    output logic [31:0] alu_operand_b,
    output logic [2:0]  alu_operation,
    input  logic [31:0] alu_result,
    input  logic        alu_exception,
    input  logic        alu_overflow,
    input  logic        alu_underflow,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_result,
    output logic        resp_exception,
    output logic        resp_overflow,
    output logic        resp_underflow,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for a request; ALU parked
    // ISSUE | ALU inputs driven, settle counter running
    // RESP  | response held until consumer accepts; ALU parked
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        id_q, id_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [2:0]  op_q, op_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic        idle;
    logic        grant;
    logic        accept;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [2:0]  sel_op;

    // With both valid the port that did not win last time gets the grant.
    assign idle   = (state_q == IDLE);
    assign grant  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign accept = idle && (req0_valid || req1_valid);

    assign req0_ready = idle && req0_valid && !grant;
    assign req1_ready = idle && req1_valid && grant;

    assign sel_a  = grant ? req1_operand_a : req0_operand_a;
    assign sel_b  = grant ? req1_operand_b : req0_operand_b;
    assign sel_op = grant ? req1_operation : req0_operation;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            opa_q        <= '0;
            opb_q        <= '0;
            op_q         <= '0;
            cnt_q        <= '0;
            res_q        <= '0;
            exc_q        <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            res_q        <= res_d;
            exc_q        <= exc_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        exc_d        = exc_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    opa_d        = sel_a;
                    opb_d        = sel_b;
                    op_d         = sel_op;
                    id_d         = grant;
                    last_grant_d = grant;
                    if (sel_op != 3'd0) begin
                        cnt_d   = SETTLE_LOAD;
                        state_d = ISSUE;
                    end else begin
                        // Illegal opcode: answer immediately, never touch the ALU.
                        res_d   = '0;
                        exc_d   = 1'b1;
                        ovf_d   = 1'b0;
                        unf_d   = 1'b0;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == 4'd0) begin
                    res_d   = alu_result;
                    exc_d   = alu_exception;
                    ovf_d   = alu_overflow;
                    unf_d   = alu_underflow;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign alu_operand_a = (state_q == ISSUE) ? opa_q : '0;
    assign alu_operand_b = (state_q == ISSUE) ? opb_q : '0;
    assign alu_operation = (state_q == ISSUE) ? op_q  : '0;

    assign resp_valid     = (state_q == RESP);
    assign resp_id        = id_q;
    assign resp_result    = res_q;
    assign resp_exception = exc_q;
    assign resp_overflow  = ovf_q;
    assign resp_underflow = unf_q;
    assign busy           = !idle;

endmodule

// File: tb/tb_alu_access_ctrl.sv
// Directed bench for alu_access_ctrl with a small stand-in ALU model.
module tb_alu_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_operand_a = '0, req1_operand_a = '0;
    logic [31:0] req0_operand_b = '0, req1_operand_b = '0;
    logic [2:0]  req0_operation = '0, req1_operation = '0;
    logic [31:0] alu_operand_a, alu_operand_b;
    logic [2:0]  alu_operation;
    logic [31:0] alu_result;
    logic        alu_exception, alu_overflow, alu_underflow;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_id;
    logic [31:0] resp_result;
    logic        resp_exception, resp_overflow, resp_underflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_access_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_operand_a(req0_operand_a), .req1_operand_a(req1_operand_a),
        .req0_operand_b(req0_operand_b), .req1_operand_b(req1_operand_b),
        .req0_operation(req0_operation), .req1_operation(req1_operation),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_operation(alu_operation),
        .alu_result(alu_result), .alu_exception(alu_exception),
        .alu_overflow(alu_overflow), .alu_underflow(alu_underflow),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_exception(resp_exception),
        .resp_overflow(resp_overflow), .resp_underflow(resp_underflow),
        .busy(busy)
    );

    // Stand-in ALU: one real FP add vector, +inf raises exception, otherwise a^b^op.
    always_comb begin
        alu_result    = '0;
        alu_exception = 1'b0;
        alu_overflow  = 1'b0;
        alu_underflow = 1'b0;
        if (alu_operation != 3'd0) begin
            if (alu_operand_a == 32'h7F800000) begin
                alu_exception = 1'b1;
            end else if (alu_operation == 3'd1 && alu_operand_a == 32'h3F800000 &&
                         alu_operand_b == 32'h40000000) begin
                alu_result = 32'h40400000;
            end else begin
                alu_result    = alu_operand_a ^ alu_operand_b ^ {29'd0, alu_operation};
                alu_overflow  = (alu_operation == 3'd3);
                alu_underflow = (alu_operation == 3'd4);
            end
        end
    end

    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 40);
        if (!resp_valid) n = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
        checks++; if (alu_operation !== 3'd0 || alu_operand_a !== 32'd0 || alu_operand_b !== 32'd0) begin
            errors++; $display("FAIL reset_alu got op %0d a %h b %h want 0", alu_operation, alu_operand_a, alu_operand_b); end
        checks++; if (resp_result !== 32'd0 || resp_id !== 1'b0 || {resp_exception, resp_overflow, resp_underflow} !== 3'b000) begin
            errors++; $display("FAIL reset_resp got res %h id %b flags %b want 0", resp_result, resp_id, {resp_exception, resp_overflow, resp_underflow}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_add;
        @(negedge clk);
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_operand_a = 32'h3F800000; req0_operand_b = 32'h40000000; req0_operation = 3'd1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL add_ready got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clk);
        req0_valid = 1'b0;
        checks++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL add_t1_state got busy %b rv %b want 1 0", busy, resp_valid); end
        checks++; if (alu_operation !== 3'd1 || alu_operand_b !== 32'h40000000) begin
            errors++; $display("FAIL add_t1_alu got op %0d b %h want 1 40000000", alu_operation, alu_operand_b); end
        @(negedge clk);
        checks++; if (alu_operation !== 3'd1 || alu_operand_a !== 32'h3F800000 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL add_t2_alu got op %0d a %h rv %b want 1 3f800000 0", alu_operation, alu_operand_a, resp_valid); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_result !== 32'h40400000) begin
            errors++; $display("FAIL add_t3_resp got rv %b res %h want 1 40400000", resp_valid, resp_result); end
        checks++; if (resp_id !== 1'b0 || {resp_exception, resp_overflow, resp_underflow} !== 3'b000 || alu_operation !== 3'd0) begin
            errors++; $display("FAIL add_t3_meta got id %b flags %b op %0d want 0 000 0", resp_id, {resp_exception, resp_overflow, resp_underflow}, alu_operation); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_done got rv %b busy %b want 0 0", resp_valid, busy); end
    endtask

    task automatic test_contention;
        int n;
        @(negedge clk);
        rst_n = 1'b0;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_operand_a = 32'h10;  req0_operand_b = 32'h1;  req0_operation = 3'd3;
        req1_valid = 1'b1; req1_operand_a = 32'h100; req1_operand_b = 32'h20; req1_operation = 3'd2;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL cont_first_grant got %b want 10", {req0_ready, req1_ready}); end
        for (int i = 0; i < 4; i++) begin
            wait_resp(n);
            if (i == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            if (i > 0) begin
                checks++; if (n !== 4) begin errors++; $display("FAIL cont_interval op %0d got %0d want 4", i, n); end
            end
            checks++; if (resp_id !== 1'(i % 2)) begin errors++; $display("FAIL cont_id op %0d got %b want %0d", i, resp_id, i % 2); end
            if (i % 2 == 0) begin
                checks++; if (resp_result !== 32'h12 || resp_overflow !== 1'b1) begin
                    errors++; $display("FAIL cont_res0 op %0d got %h ovf %b want 12 1", i, resp_result, resp_overflow); end
            end else begin
                checks++; if (resp_result !== 32'h122 || resp_overflow !== 1'b0) begin
                    errors++; $display("FAIL cont_res1 op %0d got %h ovf %b want 122 0", i, resp_result, resp_overflow); end
            end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle got busy %b want 0", busy); end
    endtask

    task automatic test_back_pressure;
        int n;
        @(negedge clk);
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_operand_a = 32'h5; req0_operand_b = 32'h3; req0_operation = 3'd2;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_operand_a = 32'h1; req1_operand_b = 32'h2; req1_operation = 3'd6;
        wait_resp(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL bp_latency got %0d want 2", n); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (resp_valid !== 1'b1 || resp_result !== 32'h4 || resp_id !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc %0d got rv %b res %h id %b want 1 4 0", k, resp_valid, resp_result, resp_id); end
            checks++; if ({req0_ready, req1_ready} !== 2'b00 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_ready cyc %0d got rdy %b busy %b want 00 1", k, {req0_ready, req1_ready}, busy); end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req1_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_next_ready got rdy1 %b rv %b want 1 0", req1_ready, resp_valid); end
        @(negedge clk);
        req1_valid = 1'b0;
        wait_resp(n);
        checks++; if (n !== 2 || resp_result !== 32'h5 || resp_id !== 1'b1) begin
            errors++; $display("FAIL bp_next_resp got n %0d res %h id %b want 2 5 1", n, resp_result, resp_id); end
    endtask

    task automatic test_opcode0;
        @(negedge clk);
        resp_ready = 1'b0;
        req1_valid = 1'b1; req1_operand_a = 32'h1234; req1_operand_b = 32'h1; req1_operation = 3'd0;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL op0_ready got %b want 1", req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_result !== 32'd0 || resp_id !== 1'b1) begin
            errors++; $display("FAIL op0_resp got rv %b res %h id %b want 1 0 1", resp_valid, resp_result, resp_id); end
        checks++; if ({resp_exception, resp_overflow, resp_underflow} !== 3'b100) begin
            errors++; $display("FAIL op0_flags got %b want 100", {resp_exception, resp_overflow, resp_underflow}); end
        checks++; if (alu_operation !== 3'd0 || alu_operand_a !== 32'd0) begin
            errors++; $display("FAIL op0_alu_parked got op %0d a %h want 0 0", alu_operation, alu_operand_a); end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL op0_done got rv %b want 0", resp_valid); end
    endtask

    task automatic test_flags;
        int n;
        @(negedge clk);
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_operand_a = 32'h7F800000; req0_operand_b = 32'h0; req0_operation = 3'd5;
        @(negedge clk);
        req0_valid = 1'b0;
        wait_resp(n);
        checks++; if (n !== 2 || resp_exception !== 1'b1 || resp_result !== 32'd0 || resp_id !== 1'b0) begin
            errors++; $display("FAIL flags_resp got n %0d exc %b res %h id %b want 2 1 0 0", n, resp_exception, resp_result, resp_id); end
    endtask

    task automatic test_reset_mid_issue;
        int n;
        logic seen;
        @(negedge clk);
        req0_valid = 1'b1; req0_operand_a = 32'h3F800000; req0_operand_b = 32'h40000000; req0_operation = 3'd1;
        @(negedge clk);
        req0_valid = 1'b0;
        checks++; if (busy !== 1'b1 || alu_operation !== 3'd1) begin
            errors++; $display("FAIL rmi_in_issue got busy %b op %0d want 1 1", busy, alu_operation); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || alu_operation !== 3'd0 || alu_operand_a !== 32'd0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL rmi_cleared got busy %b op %0d a %h rv %b want 0 0 0 0", busy, alu_operation, alu_operand_a, resp_valid); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmi_no_resp got rv seen %b want 0", seen); end
        req1_valid = 1'b1; req1_operand_a = 32'h8; req1_operand_b = 32'h1; req1_operation = 3'd4;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rmi_fresh_ready got %b want 1", req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0;
        wait_resp(n);
        checks++; if (n !== 2 || resp_result !== 32'hD || resp_id !== 1'b1 || resp_underflow !== 1'b1) begin
            errors++; $display("FAIL rmi_fresh_resp got n %0d res %h id %b unf %b want 2 d 1 1", n, resp_result, resp_id, resp_underflow); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_back_pressure();
        test_opcode0();
        test_flags();
        test_reset_mid_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
